// File: rtl/dram_bank_responder.sv
// Single-bank DRAM responder: tracks the open row, enforces tRCD/tRAS/tRP/tWR/CL timing.
// Define BANK_RESP_VIOL_EN to build the protocol-violation detector (viol/viol_code).
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module dram_bank_responder #(
    parameter int BANK_ID = 0,
    parameter int T_RCD   = 4,
    parameter int T_RAS   = 10,
    parameter int T_RP    = 4,
    parameter int T_WR    = 4,
    parameter int T_CL    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [2:0]            cmd,
    input  logic [2:0]            bank,
    input  logic [`ADDR_BITS-1:0] addr,
    output logic                  bank_open,
    output logic [`ADDR_BITS-1:0] open_row,
    output logic                  rd_valid,
    output logic [`ADDR_BITS-1:0] rd_col,
    output logic                  wr_ack,
    output logic                  busy,
    output logic                  viol,
    output logic [2:0]            viol_code
);
    localparam int AW = `ADDR_BITS;

    localparam logic [2:0] CmdNop = 3'd0;
    localparam logic [2:0] CmdAct = 3'd1;
    localparam logic [2:0] CmdRd  = 3'd2;
    localparam logic [2:0] CmdWr  = 3'd3;
    localparam logic [2:0] CmdPre = 3'd4;
    localparam logic [2:0] CmdRda = 3'd5;
    localparam logic [2:0] CmdWra = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StActivating,
        StActive,
        StAutoPre,
        StPrecharging
    } state_e;

    state_e          state_q, state_d, eff_state;
    logic [4:0]      rcd_q, rcd_d, ras_q, ras_d, rp_q, rp_d, wr_q, wr_d;
    logic [AW-1:0]   row_q, row_d;
    logic            wr_ack_q, wr_ack_d;
    logic            push;
    logic            ours;

    logic            pipe_v [T_CL];
    logic [AW-1:0]   pipe_c [T_CL];
    logic            rd_valid_q;
    logic [AW-1:0]   rd_col_q;

    function automatic logic [4:0] dec(input logic [4:0] v);
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
    endfunction

    assign ours = cmd_valid && (bank == 3'(BANK_ID)) && (cmd != CmdNop);

    // A timer that has just expired makes the bank behave as if already in the next state.
    always_comb begin
        eff_state = state_q;
        if (state_q == StActivating && rcd_q == 5'd0) eff_state = StActive;
        if (state_q == StPrecharging && rp_q == 5'd0) eff_state = StIdle;
    end

    always_comb begin
        state_d  = eff_state;
        rcd_d    = dec(rcd_q);
        ras_d    = dec(ras_q);
        rp_d     = dec(rp_q);
        wr_d     = dec(wr_q);
        row_d    = row_q;
        wr_ack_d = 1'b0;
        push     = 1'b0;
        if (eff_state == StAutoPre && ras_q == 5'd0 && wr_q == 5'd0) begin
            state_d = StPrecharging;
            rp_d    = 5'(T_RP - 1);
        end
        if (ours) begin
            case (eff_state)
                StIdle: begin
                    if (cmd == CmdAct) begin
                        row_d   = addr;
                        rcd_d   = 5'(T_RCD - 1);
                        ras_d   = 5'(T_RAS - 1);
                        state_d = StActivating;
                    end
                end
                StActive: begin
                    if (cmd == CmdRd || cmd == CmdRda) push = 1'b1;
                    if (cmd == CmdWr || cmd == CmdWra) begin
                        wr_d     = 5'(T_WR - 1);
                        wr_ack_d = 1'b1;
                    end
                    if (cmd == CmdRda || cmd == CmdWra) state_d = StAutoPre;
                    if (cmd == CmdPre && ras_q == 5'd0 && wr_q == 5'd0) begin
                        rp_d    = 5'(T_RP - 1);
                        state_d = StPrecharging;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rcd_q    <= 5'd0;
            ras_q    <= 5'd0;
            rp_q     <= 5'd0;
            wr_q     <= 5'd0;
            row_q    <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcd_q    <= rcd_d;
            ras_q    <= ras_d;
            rp_q     <= rp_d;
            wr_q     <= wr_d;
            row_q    <= row_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    // Column is zeroed in empty slots so rd_col reads 0 whenever rd_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T_CL; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_c[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_col_q   <= '0;
        end else begin
            pipe_v[0] <= push;
            pipe_c[0] <= push ? addr : '0;
            for (int i = 1; i < T_CL; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_c[i] <= pipe_c[i-1];
            end
            rd_valid_q <= pipe_v[T_CL-1];
            rd_col_q   <= pipe_c[T_CL-1];
        end
    end

    assign bank_open = (state_q == StActivating) || (state_q == StActive);
    assign open_row  = row_q;
    assign busy      = !((state_q == StIdle) || (state_q == StActive));
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_col    = rd_col_q;

`ifdef BANK_RESP_VIOL_EN
    logic [2:0] code_d, code_q;
    logic       viol_q;

    always_comb begin
        code_d = 3'd0;
        if (ours) begin
            if (cmd == 3'd7) begin
                code_d = 3'd5;
            end else begin
                case (eff_state)
                    StIdle:       if (cmd != CmdAct) code_d = 3'd1;
                    StActivating: code_d = (cmd == CmdAct) ? 3'd1 : 3'd2;
                    StActive: begin
                        if (cmd == CmdAct) begin
                            code_d = 3'd1;
                        end else if (cmd == CmdPre) begin
                            if (ras_q != 5'd0)     code_d = 3'd3;
                            else if (wr_q != 5'd0) code_d = 3'd4;
                        end
                    end
                    default:      code_d = 3'd2;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q <= 1'b0;
            code_q <= 3'd0;
        end else begin
            viol_q <= (code_d != 3'd0);
            code_q <= code_d;
        end
    end

    assign viol      = viol_q;
    assign viol_code = code_q;
`else
    assign viol      = 1'b0;
    assign viol_code = 3'd0;
`endif

endmodule

// File: tb/tb_dram_bank_responder.sv
// Bench for dram_bank_responder: timestamp-based bank model checked every cycle, plus
// directed scenarios with hand-computed expectations.
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module tb_dram_bank_responder;
    localparam int AW   = `ADDR_BITS;
    localparam int BID  = 0;
    localparam int TRCD = 4;
    localparam int TRAS = 10;
    localparam int TRP  = 4;
    localparam int TWR  = 4;
    localparam int TCL  = 5;

    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;
    localparam logic [2:0] RDA = 3'd5, WRA = 3'd6, ILL = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [2:0]    bank = 3'd0;
    logic [AW-1:0] addr = '0;
    logic          bank_open, rd_valid, wr_ack, busy, viol;
    logic [AW-1:0] open_row, rd_col;
    logic [2:0]    viol_code;

    int checks = 0;
    int errors = 0;

    dram_bank_responder #(
        .BANK_ID(BID), .T_RCD(TRCD), .T_RAS(TRAS), .T_RP(TRP), .T_WR(TWR), .T_CL(TCL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .bank(bank),
        .addr(addr), .bank_open(bank_open), .open_row(open_row), .rd_valid(rd_valid),
        .rd_col(rd_col), .wr_ack(wr_ack), .busy(busy), .viol(viol), .viol_code(viol_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: the bank as a set of timestamps ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] col;
    } rd_t;

    rd_t           rq[$];
    int            now = 0;
    bit            m_open = 0;
    int            act_t = -1000, wr_t = -1000, pre_t = -1000;
    int            m_code = 0;
    logic [AW-1:0] m_row = '0;

    logic          e_open = 0, e_busy = 0, e_rdv = 0, e_wrack = 0, e_viol = 0;
    logic [AW-1:0] e_row = '0, e_rdcol = '0;
    logic [2:0]    e_code = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
            m_open = 0; act_t = -1000; wr_t = -1000; pre_t = -1000; m_row = '0;
            e_open = 0; e_busy = 0; e_rdv = 0; e_wrack = 0; e_viol = 0;
            e_row = '0; e_rdcol = '0; e_code = 0;
        end else begin
            now = now + 1;
            e_wrack = 0;
            m_code = 0;
            if (cmd_valid && bank == 3'(BID) && cmd != NOP) begin
                if (cmd == ILL) m_code = 5;
                else if (!m_open) begin
                    if (now < pre_t + TRP) m_code = 2;
                    else if (cmd != ACT) m_code = 1;
                    else begin
                        m_open = 1; act_t = now; m_row = addr;
                    end
                end else begin
                    if (cmd == ACT) m_code = 1;
                    else if (now < act_t + TRCD) m_code = 2;
                    else if (cmd == PRE) begin
                        if (now < act_t + TRAS) m_code = 3;
                        else if (now < wr_t + TWR) m_code = 4;
                        else begin
                            m_open = 0; pre_t = now;
                        end
                    end else begin
                        if (cmd == RD || cmd == RDA) rq.push_back('{now + TCL, addr});
                        if (cmd == WR || cmd == WRA) begin
                            wr_t = now; e_wrack = 1;
                        end
                        if (cmd == RDA || cmd == WRA) begin
                            m_open = 0;
                            pre_t = max3(act_t + TRAS, wr_t + TWR, now + 1);
                        end
                    end
                end
            end
`ifdef BANK_RESP_VIOL_EN
            e_viol = (m_code != 0);
            e_code = 3'(m_code);
`endif
            e_rdv = 0;
            e_rdcol = '0;
            if (rq.size() > 0 && rq[0].due == now) begin
                e_rdv = 1;
                e_rdcol = rq[0].col;
                void'(rq.pop_front());
            end
            e_open = m_open;
            e_row = m_row;
            e_busy = m_open ? (now < act_t + TRCD) : (now < pre_t + TRP);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("bank_open", bank_open, e_open);
        chk("open_row", open_row, e_row);
        chk("rd_valid", rd_valid, e_rdv);
        chk("rd_col", rd_col, e_rdcol);
        chk("wr_ack", wr_ack, e_wrack);
        chk("busy", busy, e_busy);
        chk("viol", viol, e_viol);
        chk("viol_code", viol_code, e_code);
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc_raw(input logic v, input logic [2:0] c, input logic [2:0] b,
                           input logic [AW-1:0] a);
        @(negedge clk);
        cmd_valid = v; cmd = c; bank = b; addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [2:0] c, input logic [AW-1:0] a);
        cyc_raw(1'b1, c, 3'(BID), a);
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) cyc_raw(1'b0, NOP, 3'd0, '0);
    endtask

    task automatic chk_viol(input string name, input logic [2:0] code);
`ifdef BANK_RESP_VIOL_EN
        chk({name, "_viol"}, viol, 1'b1);
        chk({name, "_code"}, viol_code, code);
`else
        chk({name, "_viol"}, viol, {1'b0, code & 3'd0});
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_open", bank_open, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Basic ACT then RD: strobe CL after the read.
        cyc(ACT, 14'h1A3);                                   // t0
        chk("t1_open", bank_open, 1'b1);
        chk("t1_row", open_row, 14'h1A3);
        nops(3);                                             // t1..3
        chk("t1_busy_rcd", busy, 1'b1);
        cyc(RD, 14'h008);                                    // t4
        chk("t1_busy_active", busy, 1'b0);
        nops(4);                                             // t5..8
        chk("t1_rd_early", rd_valid, 1'b0);
        nops(1);                                             // t9
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_rd_col", rd_col, 14'h008);
        nops(1);                                             // t10
        chk("t1_rd_once", rd_valid, 1'b0);
        cyc(ACT, 14'h011);                                   // t11
        chk_viol("t1_act_active", 3'd1);
        cyc(PRE, 14'h000);                                   // t12
        chk("t1_closed", bank_open, 1'b0);
        chk("t1_row_hold", open_row, 14'h1A3);
        nops(5);

        // RD inside tRCD is rejected and never returns data.
        cyc(ACT, 14'h055);                                   // t0
        nops(1);
        cyc(RD, 14'h022);                                    // t2
        chk_viol("t2_rd_rcd", 3'd2);
        nops(7);                                             // t3..9
        chk("t2_no_rd", rd_valid, 1'b0);
        cyc(PRE, 14'h000);                                   // t10
        chk("t2_pre", bank_open, 1'b0);
        nops(5);

        // tRAS, tRP and tWR boundaries.
        cyc(ACT, 14'h0F0);                                   // t0
        nops(3);
        cyc(WR, 14'h004);                                    // t4
        chk("t3_wr_ack", wr_ack, 1'b1);
        nops(1);                                             // t5
        chk("t3_wr_ack_once", wr_ack, 1'b0);
        cyc(PRE, 14'h000);                                   // t6
        chk_viol("t3_pre_ras", 3'd3);
        chk("t3_still_open", bank_open, 1'b1);
        nops(3);                                             // t7..9
        cyc(PRE, 14'h000);                                   // t10
        chk("t3_pre_ok", bank_open, 1'b0);
        nops(2);                                             // t11..12
        cyc(ACT, 14'h0AA);                                   // t13
        chk_viol("t3_act_rp", 3'd2);
        chk("t3_act_rejected", bank_open, 1'b0);
        cyc(ACT, 14'h0AA);                                   // t14
        chk("t3_act_ok", bank_open, 1'b1);
        chk("t3_row", open_row, 14'h0AA);
        nops(8);                                             // t15..22
        cyc(WR, 14'h005);                                    // t23
        cyc(PRE, 14'h000);                                   // t24
        chk_viol("t3_pre_wr", 3'd4);
        nops(2);                                             // t25..26
        cyc(PRE, 14'h000);                                   // t27
        chk("t3_pre_wr_ok", bank_open, 1'b0);
        nops(5);

        // WRA: auto-precharge once tRAS/tWR are satisfied.
        cyc(ACT, 14'h123);                                   // t0
        nops(7);                                             // t1..7
        cyc(WRA, 14'h003);                                   // t8
        chk("t4_wra_ack", wr_ack, 1'b1);
        chk("t4_busy8", busy, 1'b1);
        nops(6);                                             // t9..14
        cyc(ACT, 14'h001);                                   // t15
        chk_viol("t4_act_early", 3'd2);
        chk("t4_busy15", busy, 1'b1);
        nops(1);                                             // t16
        chk("t4_busy16", busy, 1'b0);
        chk("t4_open16", bank_open, 1'b0);

        // Back-to-back reads, then reset in the middle of the burst.
        cyc(ACT, 14'h200);                                   // t0
        nops(3);
        for (int i = 0; i < 4; i++) cyc(RD, 14'(16 + i));    // t4..7
        nops(2);                                             // t8..9
        chk("t5_rd9", rd_valid, 1'b1);
        chk("t5_col9", rd_col, 14'h010);
        nops(1);                                             // t10
        chk("t5_rd10", rd_valid, 1'b1);
        chk("t5_col10", rd_col, 14'h011);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rd", rd_valid, 1'b0);
        chk("t5_rst_open", bank_open, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nops(8);
        chk("t5_no_strobe", rd_valid, 1'b0);

        // Illegal command, wrong bank, invalid strobe.
        cyc(ILL, 14'h000);
        chk_viol("t6_ill", 3'd5);
        cyc(RD, 14'h000);
        chk_viol("t6_rd_idle", 3'd1);
        cyc_raw(1'b1, ACT, 3'(BID + 3), 14'h077);
        chk("t6_other_bank", bank_open, 1'b0);
        chk("t6_other_viol", viol, 1'b0);
        cyc_raw(1'b0, ACT, 3'(BID), 14'h077);
        chk("t6_not_valid", bank_open, 1'b0);
        nops(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
